// File: rtl/ssp_txrx_core_if.sv
// ---------------------------------------------------------------------------
// ssp_txrx_core_if
// FIFO-side handshake bundle for ssp_txrx_core.
//   tx_valid / tx_data : TX FIFO presents a word
//   tx_ack             : one-cycle pulse, word latched, FIFO may advance
//   rx_data / rx_valid : completed receive word and its one-cycle strobe
//   tx_busy            : transmitter is mid-frame
// master = FIFO / system side, slave = the serial core.
// ---------------------------------------------------------------------------
interface ssp_txrx_core_if #(
    parameter int DATA_W = 8
) ();
    logic              tx_valid;
    logic [DATA_W-1:0] tx_data;
    logic              tx_ack;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              tx_busy;

    modport master (
        output tx_valid, tx_data,
        input  tx_ack, rx_data, rx_valid, tx_busy
    );

    modport slave (
        input  tx_valid, tx_data,
        output tx_ack, rx_data, rx_valid, tx_busy
    );
endinterface

// File: rtl/ssp_txrx_core.sv
// ---------------------------------------------------------------------------
// ssp_txrx_core
// Full-duplex MSB-first SSP shifter, single clock domain (PCLK).
//   PCLK, CLEAR         : system clock, synchronous active-high reset
//   bus (slave)         : TX/RX FIFO handshake (see ssp_txrx_core_if)
//   SSPCLKIN/FSSIN/RXD  : external serial inputs, synchronised and sampled
//   SSPCLKOUT           : registered bit clock, period 2*CLK_DIV PCLK cycles
//   SSPFSSOUT, SSPTXD   : frame pulse and serial data out
//   SSPOE_B             : active-low TX output enable
// TX launches everything on the PCLK cycle in which SSPCLKOUT rises; RX acts
// on a detected rising edge of the synchronised SSPCLKIN. A frame is one FSS
// period followed by DATA_W data periods.
// ---------------------------------------------------------------------------
module ssp_txrx_core #(
    parameter int DATA_W      = 8,
    parameter int CLK_DIV     = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 PCLK,
    input  logic                 CLEAR,
    ssp_txrx_core_if.slave       bus,
    input  logic                 SSPCLKIN,
    input  logic                 SSPFSSIN,
    input  logic                 SSPRXD,
    output logic                 SSPCLKOUT,
    output logic                 SSPFSSOUT,
    output logic                 SSPTXD,
    output logic                 SSPOE_B
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int CNT_W = $clog2(DATA_W);

    typedef enum logic [1:0] {T_IDLE, T_SYNC, T_SHIFT} tx_state_t;
    typedef enum logic [1:0] {R_IDLE, R_ARM, R_SHIFT} rx_state_t;

    // ------------------------------------------------------------------
    // Bit-clock divider
    // ------------------------------------------------------------------
    logic [DIV_W-1:0] div_cnt;
    logic             div_tc;
    logic             rise_tick;

    assign div_tc    = (div_cnt == DIV_W'(CLK_DIV - 1));
    // SSPCLKOUT is about to go 0->1 at the end of this cycle.
    assign rise_tick = div_tc & ~SSPCLKOUT;

    always_ff @(posedge PCLK) begin
        if (CLEAR) begin
            div_cnt   <= '0;
            SSPCLKOUT <= 1'b0;
        end else if (div_tc) begin
            div_cnt   <= '0;
            SSPCLKOUT <= ~SSPCLKOUT;
        end else begin
            div_cnt   <= div_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // TX FSM
    // ------------------------------------------------------------------
    tx_state_t         tx_state, tx_state_n;
    logic [DATA_W-1:0] tx_sh, tx_sh_n;
    logic [CNT_W-1:0]  tx_cnt, tx_cnt_n;
    logic              fss_n, oe_b_n, txd_n, ack_n;

    always_comb begin
        tx_state_n = tx_state;
        tx_sh_n    = tx_sh;
        tx_cnt_n   = tx_cnt;
        fss_n      = SSPFSSOUT;
        oe_b_n     = SSPOE_B;
        txd_n      = SSPTXD;
        ack_n      = 1'b0;
        if (rise_tick) begin
            case (tx_state)
                T_IDLE: begin
                    if (bus.tx_valid) begin
                        tx_sh_n    = bus.tx_data;
                        ack_n      = 1'b1;
                        fss_n      = 1'b1;
                        tx_state_n = T_SYNC;
                    end else begin
                        fss_n      = 1'b0;
                    end
                end
                T_SYNC: begin
                    fss_n      = 1'b0;
                    oe_b_n     = 1'b0;
                    txd_n      = tx_sh[DATA_W-1];
                    tx_cnt_n   = CNT_W'(DATA_W - 1);
                    tx_state_n = T_SHIFT;
                end
                T_SHIFT: begin
                    if (tx_cnt != '0) begin
                        // tx_cnt is the index of the bit currently on SSPTXD
                        txd_n    = tx_sh[tx_cnt - 1'b1];
                        tx_cnt_n = tx_cnt - 1'b1;
                    end else begin
                        oe_b_n = 1'b1;
                        txd_n  = 1'b0;
                        // Back-to-back: next FSS starts right after bit 0.
                        if (bus.tx_valid) begin
                            tx_sh_n    = bus.tx_data;
                            ack_n      = 1'b1;
                            fss_n      = 1'b1;
                            tx_state_n = T_SYNC;
                        end else begin
                            tx_state_n = T_IDLE;
                        end
                    end
                end
                default: tx_state_n = T_IDLE;
            endcase
        end
    end

    always_ff @(posedge PCLK) begin
        if (CLEAR) begin
            tx_state  <= T_IDLE;
            tx_sh     <= '0;
            tx_cnt    <= '0;
            SSPFSSOUT <= 1'b0;
            SSPOE_B   <= 1'b1;
            SSPTXD    <= 1'b0;
        end else begin
            tx_state  <= tx_state_n;
            tx_sh     <= tx_sh_n;
            tx_cnt    <= tx_cnt_n;
            SSPFSSOUT <= fss_n;
            SSPOE_B   <= oe_b_n;
            SSPTXD    <= txd_n;
        end
    end

    // Ack is issued in the latching cycle so the FIFO pops on the same edge.
    assign bus.tx_ack  = ack_n & ~CLEAR;
    assign bus.tx_busy = (tx_state != T_IDLE);

    // ------------------------------------------------------------------
    // RX synchronisers and edge detect
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] clk_sync, fss_sync, rxd_sync;
    logic                   clk_prev;
    logic                   s_clk, s_fss, s_rxd, clk_rise;

    assign s_clk    = clk_sync[SYNC_STAGES-1];
    assign s_fss    = fss_sync[SYNC_STAGES-1];
    assign s_rxd    = rxd_sync[SYNC_STAGES-1];
    assign clk_rise = s_clk & ~clk_prev;

    always_ff @(posedge PCLK) begin
        if (CLEAR) begin
            clk_sync <= '0;
            fss_sync <= '0;
            rxd_sync <= '0;
            clk_prev <= 1'b0;
        end else begin
            clk_sync <= {clk_sync[SYNC_STAGES-2:0], SSPCLKIN};
            fss_sync <= {fss_sync[SYNC_STAGES-2:0], SSPFSSIN};
            rxd_sync <= {rxd_sync[SYNC_STAGES-2:0], SSPRXD};
            clk_prev <= s_clk;
        end
    end

    // ------------------------------------------------------------------
    // RX FSM
    // ------------------------------------------------------------------
    rx_state_t         rx_state, rx_state_n;
    logic [DATA_W-1:0] rx_sh, rx_sh_n;
    logic [CNT_W-1:0]  rx_cnt, rx_cnt_n;
    logic [DATA_W-1:0] rx_data_q, rx_data_n;
    logic              rx_valid_q, rx_valid_n;

    always_comb begin
        rx_state_n = rx_state;
        rx_sh_n    = rx_sh;
        rx_cnt_n   = rx_cnt;
        rx_data_n  = rx_data_q;
        rx_valid_n = 1'b0;
        if (clk_rise) begin
            if (s_fss) begin
                // Frame start always wins, discarding any partial word.
                rx_state_n = R_ARM;
                rx_cnt_n   = '0;
            end else begin
                case (rx_state)
                    R_ARM: begin
                        rx_sh_n[DATA_W-1] = s_rxd;
                        rx_cnt_n          = CNT_W'(DATA_W - 2);
                        rx_state_n        = R_SHIFT;
                    end
                    R_SHIFT: begin
                        rx_sh_n[rx_cnt] = s_rxd;
                        if (rx_cnt == '0) begin
                            rx_data_n  = {rx_sh[DATA_W-1:1], s_rxd};
                            rx_valid_n = 1'b1;
                            rx_state_n = R_IDLE;
                        end else begin
                            rx_cnt_n = rx_cnt - 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge PCLK) begin
        if (CLEAR) begin
            rx_state   <= R_IDLE;
            rx_sh      <= '0;
            rx_cnt     <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            rx_state   <= rx_state_n;
            rx_sh      <= rx_sh_n;
            rx_cnt     <= rx_cnt_n;
            rx_data_q  <= rx_data_n;
            rx_valid_q <= rx_valid_n;
        end
    end

    assign bus.rx_data  = rx_data_q;
    assign bus.rx_valid = rx_valid_q;

endmodule

// File: tb/tb_ssp_txrx_core.sv
// ---------------------------------------------------------------------------
// tb_ssp_txrx_core
// dut_a: DATA_W=8, CLK_DIV=2, external RX driven by the bench.
// dut_b: DATA_W=12, CLK_DIV=3, pins looped back TX->RX.
// ---------------------------------------------------------------------------
module tb_ssp_txrx_core;

    logic PCLK  = 1'b0;
    logic CLEAR = 1'b1;
    always #5 PCLK = ~PCLK;

    int checks = 0;
    int errors = 0;

    ssp_txrx_core_if #(.DATA_W(8))  ia ();
    ssp_txrx_core_if #(.DATA_W(12)) ib ();

    logic ext_clk = 1'b0, ext_fss = 1'b0, ext_rxd = 1'b0;
    logic a_clkout, a_fssout, a_txd, a_oe_b;
    logic b_clk, b_fss, b_txd, b_oe_b;

    ssp_txrx_core #(.DATA_W(8), .CLK_DIV(2), .SYNC_STAGES(2)) dut_a (
        .PCLK(PCLK), .CLEAR(CLEAR), .bus(ia),
        .SSPCLKIN(ext_clk), .SSPFSSIN(ext_fss), .SSPRXD(ext_rxd),
        .SSPCLKOUT(a_clkout), .SSPFSSOUT(a_fssout), .SSPTXD(a_txd), .SSPOE_B(a_oe_b)
    );

    ssp_txrx_core #(.DATA_W(12), .CLK_DIV(3), .SYNC_STAGES(2)) dut_b (
        .PCLK(PCLK), .CLEAR(CLEAR), .bus(ib),
        .SSPCLKIN(b_clk), .SSPFSSIN(b_fss), .SSPRXD(b_txd),
        .SSPCLKOUT(b_clk), .SSPFSSOUT(b_fss), .SSPTXD(b_txd), .SSPOE_B(b_oe_b)
    );

    // Event monitors, sampled on the falling edge.
    int          cyc = 0;
    int          ack_a[$];
    logic [7:0]  rxq_a[$];
    logic [11:0] rxq_b[$];

    always @(negedge PCLK) begin
        cyc++;
        if (ia.tx_ack === 1'b1)   ack_a.push_back(cyc);
        if (ia.rx_valid === 1'b1) rxq_a.push_back(ia.rx_data);
        if (ib.rx_valid === 1'b1) rxq_b.push_back(ib.rx_data);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: timed out", nm);
    endtask

    // Present w0 (then w1) and advance on each ack; n words total.
    task automatic drive_a(input logic [7:0] w0, input logic [7:0] w1, input int n);
        int k = 0;
        int t = 0;
        ia.tx_data  = w0;
        ia.tx_valid = 1'b1;
        while (k < n && t < 500) begin
            @(negedge PCLK);
            t++;
            if (ia.tx_ack === 1'b1) begin
                k++;
                @(posedge PCLK);
                #1;
                if (k < n) ia.tx_data = w1;
                else       ia.tx_valid = 1'b0;
            end
        end
        if (k < n) begin
            ia.tx_valid = 1'b0;
            fail_now("tx ack wait");
        end
    endtask

    // Expected pin behaviour of one dut_a frame (period 4 PCLK):
    // FSS high 4 cycles, then each bit MSB-first for 4 cycles with OE_B=0,
    // then OE_B=1/TXD=0, FSS high again only if a back-to-back word follows.
    task automatic check_frame(input logic [7:0] w, input logic b2b, input string nm);
        int         t    = 0;
        int         hi   = 0;
        int         herr = 0;
        logic [7:0] obs  = '0;
        while (a_fssout !== 1'b1 && t < 400) begin
            @(negedge PCLK);
            t++;
        end
        if (t >= 400) begin
            fail_now({nm, " fss start"});
            return;
        end
        while (a_fssout === 1'b1 && hi < 100) begin
            hi++;
            @(negedge PCLK);
        end
        chk({nm, " fss length"}, hi, 4);
        for (int b = 7; b >= 0; b--) begin
            for (int c = 0; c < 4; c++) begin
                if (c == 0) obs[b] = a_txd;
                if (a_txd !== w[b] || a_oe_b !== 1'b0 || a_fssout !== 1'b0) herr++;
                @(negedge PCLK);
            end
        end
        chk({nm, " tx bits"}, obs, w);
        chk({nm, " bit hold/oe errors"}, herr, 0);
        chk({nm, " tail oe_b,txd,fss"}, {a_oe_b, a_txd, a_fssout}, {1'b1, 1'b0, b2b});
    endtask

    // External bit period: 4 PCLK low then 4 high (>= SYNC_STAGES+1).
    task automatic ext_bit(input logic f, input logic d);
        ext_fss = f;
        ext_rxd = d;
        repeat (4) @(negedge PCLK);
        ext_clk = 1'b1;
        repeat (4) @(negedge PCLK);
        ext_clk = 1'b0;
    endtask

    task automatic send_ext(input logic [7:0] w, input int nbits);
        ext_bit(1'b1, 1'b0);
        for (int i = 0; i < nbits; i++) ext_bit(1'b0, w[7 - i]);
        ext_fss = 1'b0;
        ext_rxd = 1'b0;
    endtask

    typedef struct {
        logic [7:0] tx_word;
        logic [7:0] pre_word;   // aborted partial frame, if pre_bits > 0
        int         pre_bits;
        logic [7:0] rx_word;
        logic [7:0] exp_rx;
    } vec_t;

    // Simultaneous TX frame and external RX frame on dut_a.
    task automatic run_vec(input vec_t v, input string nm);
        ack_a.delete();
        rxq_a.delete();
        fork
            drive_a(v.tx_word, 8'h00, 1);
            begin
                @(negedge PCLK);
                check_frame(v.tx_word, 1'b0, nm);
            end
            begin
                if (v.pre_bits > 0) send_ext(v.pre_word, v.pre_bits);
                send_ext(v.rx_word, 8);
            end
        join
        repeat (8) @(negedge PCLK);
        chk({nm, " ack count"}, ack_a.size(), 1);
        chk({nm, " rx_valid count"}, rxq_a.size(), 1);
        if (rxq_a.size() > 0) chk({nm, " rx_data"}, rxq_a[0], v.exp_rx);
    endtask

    vec_t        vecs[5];
    vec_t        rv;
    logic [11:0] wb[$];
    int          k, t;

    initial begin
        vecs[0] = '{8'hA5, 8'h00, 0, 8'h5A, 8'h5A};
        vecs[1] = '{8'h55, 8'h00, 0, 8'hAA, 8'hAA};
        vecs[2] = '{8'h3C, 8'hF0, 4, 8'h81, 8'h81};
        vecs[3] = '{8'hFF, 8'hFF, 7, 8'h7E, 8'h7E};
        vecs[4] = '{8'h00, 8'h00, 0, 8'hFF, 8'hFF};

        ia.tx_valid = 1'b0;
        ia.tx_data  = '0;
        ib.tx_valid = 1'b0;
        ib.tx_data  = '0;

        // Power-on reset values.
        repeat (3) @(negedge PCLK);
        chk("reset a outs", {a_clkout, a_fssout, a_txd, a_oe_b, ia.tx_ack, ia.tx_busy, ia.rx_valid},
            7'b0001000);
        chk("reset a rx_data", ia.rx_data, 0);
        chk("reset b outs", {b_clk, b_fss, b_txd, b_oe_b, ib.tx_busy, ib.rx_valid}, 6'b000100);
        CLEAR = 1'b0;
        repeat (4) @(negedge PCLK);

        // Table vectors.
        for (int i = 0; i < 5; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Randomised frames; a restart always discards the partial word.
        for (int i = 0; i < 4; i++) begin
            rv.tx_word  = 8'($urandom);
            rv.pre_word = 8'($urandom);
            rv.pre_bits = $urandom_range(0, 7);
            rv.rx_word  = 8'($urandom);
            rv.exp_rx   = rv.rx_word;
            run_vec(rv, $sformatf("rnd%0d", i));
        end

        // Back-to-back 0x3C, 0xC3 with tx_valid held high.
        ack_a.delete();
        fork
            drive_a(8'h3C, 8'hC3, 2);
            begin
                @(negedge PCLK);
                check_frame(8'h3C, 1'b1, "b2b first");
                check_frame(8'hC3, 1'b0, "b2b second");
            end
        join
        chk("b2b ack count", ack_a.size(), 2);
        if (ack_a.size() == 2) chk("b2b ack spacing", ack_a[1] - ack_a[0], 36);
        chk("b2b busy after", ia.tx_busy, 0);

        // Reset mid-frame on both TX and RX.
        ack_a.delete();
        rxq_a.delete();
        fork
            drive_a(8'h96, 8'h00, 1);
            send_ext(8'h77, 8);
            begin
                repeat (30) @(negedge PCLK);
                CLEAR = 1'b1;
                repeat (3) @(negedge PCLK);
                chk("midrst outs", {a_clkout, a_fssout, a_txd, a_oe_b, ia.tx_ack, ia.tx_busy, ia.rx_valid},
                    7'b0001000);
                chk("midrst rx_data", ia.rx_data, 0);
                CLEAR = 1'b0;
                @(negedge PCLK);
                chk("post-rst outs", {a_clkout, a_fssout, a_txd, a_oe_b, ia.tx_ack, ia.tx_busy, ia.rx_valid},
                    7'b0001000);
            end
        join
        repeat (12) @(negedge PCLK);
        chk("midrst ack count", ack_a.size(), 1);
        chk("midrst rx_valid count", rxq_a.size(), 0);
        chk("midrst idle", {a_oe_b, a_fssout, ia.tx_busy}, 3'b100);
        rv = '{8'h69, 8'h00, 0, 8'h42, 8'h42};
        run_vec(rv, "after-rst");

        // Loopback on dut_b: every word comes back unchanged, in order.
        wb.push_back(12'hFFF);
        wb.push_back(12'h000);
        wb.push_back(12'h5A5);
        repeat (3) wb.push_back(12'($urandom_range(0, 4095)));
        rxq_b.delete();
        ib.tx_data  = wb[0];
        ib.tx_valid = 1'b1;
        k = 0;
        t = 0;
        while (k < wb.size() && t < 2000) begin
            @(negedge PCLK);
            t++;
            if (ib.tx_ack === 1'b1) begin
                k++;
                @(posedge PCLK);
                #1;
                if (k < wb.size()) ib.tx_data = wb[k];
                else               ib.tx_valid = 1'b0;
            end
        end
        ib.tx_valid = 1'b0;
        if (k < wb.size()) fail_now("loopback ack wait");
        t = 0;
        while (rxq_b.size() < wb.size() && t < 500) begin
            @(negedge PCLK);
            t++;
        end
        repeat (100) @(negedge PCLK);
        chk("loopback rx count", rxq_b.size(), wb.size());
        for (int i = 0; i < wb.size(); i++)
            if (i < rxq_b.size()) chk($sformatf("loopback word%0d", i), rxq_b[i], wb[i]);
        chk("loopback idle", {b_oe_b, ib.tx_busy}, 2'b10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ssp_txrx_core.md
Name: ssp_txrx_core

Overview:
- Parametrised successor to the lab SSP transmit/receive logic: a full-duplex, MSB-first serial shifter.
- Configurable word width and bit-clock divider.
- Everything runs on PCLK only. Incoming SSP signals are synchronised and edge-detected rather than used as clocks.
- Sits between the TX FIFO / RX FIFO and the SSP pins.

Parameters:
- DATA_W, 8: word width in bits; legal range 4..16.
- CLK_DIV, 2: PCLK cycles per SSPCLKOUT half-period; legal range ≥1. SSPCLKOUT period = 2*CLK_DIV PCLK cycles.
- SYNC_STAGES, 2: flop stages on SSPCLKIN, SSPFSSIN and SSPRXD; legal range ≥2.

Ports:
- PCLK  in  1  system clock.
- CLEAR  in  1  synchronous, active-high reset.
- tx_valid  in  1  TX FIFO has a word on tx_data.
- tx_data  in  DATA_W  word to transmit.
- tx_ack  out  1  one-cycle pulse: tx_data latched, FIFO may advance.
- rx_data  out  DATA_W  last completely received word.
- rx_valid  out  1  one-cycle pulse: rx_data updated this cycle.
- tx_busy  out  1  high whenever the TX FSM is not in T_IDLE.
- SSPCLKIN  in  1  external serial bit clock.
- SSPFSSIN  in  1  external frame pulse.
- SSPRXD  in  1  external serial data.
- SSPCLKOUT  out  1  divided bit clock, registered.
- SSPFSSOUT  out  1  frame pulse.
- SSPTXD  out  1  serial data out.
- SSPOE_B  out  1  active-low TX output enable.

Behaviour:
- Reset: CLEAR is sampled on the PCLK rising edge. Reset values:
  - SSPCLKOUT=0, SSPFSSOUT=0, SSPTXD=0, SSPOE_B=1.
  - tx_ack=0, tx_busy=0, rx_valid=0, rx_data=0.
  - Divider counter=0; both FSMs in their idle states; synchroniser flops=0.
- Reset mid-frame aborts the frame with no tx_ack and no rx_valid.
- Divider:
  - Counts 0..CLK_DIV-1. At terminal count SSPCLKOUT toggles.
  - "rise_tick" is the PCLK cycle in which SSPCLKOUT goes 0->1.
  - All TX state changes occur only on rise_tick.
- TX FSM states: T_IDLE, T_SYNC, T_SHIFT.
  - T_IDLE, rise_tick, tx_valid=1: latch tx_data into the shift register, tx_ack=1 for exactly that cycle, SSPFSSOUT=1, go to T_SYNC. If tx_valid=0, stay idle with SSPFSSOUT=0.
  - T_SYNC, rise_tick: SSPFSSOUT=0, SSPOE_B=0, SSPTXD=MSB, bit count=DATA_W-1, go to T_SHIFT.
  - T_SHIFT, rise_tick, count>0: SSPTXD takes the next lower bit; count decrements.
  - T_SHIFT, rise_tick, count=0 (final bit has been driven one full period): SSPOE_B=1, SSPTXD=0.
    - If tx_valid=1: latch and ack as in T_IDLE, SSPFSSOUT=1, go to T_SYNC. This is the back-to-back case: no idle period, FSS pulse immediately.
    - Otherwise go to T_IDLE.
  - tx_valid is ignored outside rise_tick and outside the latch points. tx_data must be stable while tx_valid=1 until tx_ack.
  - One frame occupies DATA_W+1 SSPCLKOUT periods.
- RX path:
  - All three inputs pass through SYNC_STAGES flops.
  - clk_rise = synchronised SSPCLKIN is 1 and its previous value was 0.
  - The external half-period must be ≥ SYNC_STAGES+1 PCLK cycles; faster input is unsupported.
- RX FSM states: R_IDLE, R_ARM, R_SHIFT.
  - Any state, clk_rise with synchronised FSSIN=1: go to R_ARM and clear the bit count. A partial word in R_SHIFT is discarded with no rx_valid.
  - R_ARM, clk_rise with FSSIN=0: shift register bit DATA_W-1 takes RXD; go to R_SHIFT with count=DATA_W-2.
  - R_SHIFT, clk_rise with FSSIN=0: store RXD at bit[count], decrement count.
  - On storing bit 0: rx_data is loaded in the same cycle with the completed word, rx_valid=1 for one cycle, go to R_IDLE.
  - Last-bit edge with FSSIN=1: the frame restart wins. No rx_valid; go to R_ARM. Senders must not overlap FSS with data.
  - R_IDLE: clk_rise with FSSIN=0 is ignored.
  - rx_data holds its value between pulses. There is no backpressure; the consumer must take the word on rx_valid.
- TX and RX are fully independent and may run simultaneously. Loopback (SSPTXD->SSPRXD, SSPCLKOUT->SSPCLKIN, SSPFSSOUT->SSPFSSIN) must return every transmitted word unchanged.

Test Plan:
- Reset: assert CLEAR for 3 cycles mid-frame, release -> all outputs at their reset values; next tx_valid produces a clean frame starting with the FSS pulse.
- Single TX, DATA_W=8, CLK_DIV=2, tx_data=0xA5:
  - One tx_ack pulse.
  - SSPFSSOUT high for exactly 4 PCLK cycles.
  - Then SSPTXD = 1,0,1,0,0,1,0,1, each bit held 4 PCLK cycles, with SSPOE_B=0 throughout; then SSPOE_B=1.
- Back-to-back TX of 0x3C then 0xC3 with tx_valid held high -> two tx_ack pulses exactly 9 SSPCLKOUT periods apart; the second FSS pulse directly follows the last bit of 0x3C.
- Loopback, DATA_W=12, CLK_DIV=3, words 0xFFF, 0x000, 0x5A5 -> rx_valid pulses three times with rx_data equal to each word in order.
- RX abort: external frame, 4 bits of 0xF0, then a new FSS and a full 0x81 frame -> exactly one rx_valid, with rx_data=0x81.
- Simultaneous traffic: TX 0x55 while receiving an external 0xAA -> both complete; rx_data=0xAA; TX bit sequence unaffected.
